// File: rtl/id_issue_if.sv
// Handshake and data bundle between decode/register-read, the issue stage and EX.
// master = upstream/control side, slave = the issue stage itself.
interface id_issue_if #(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 9,
  parameter int PAY_W  = 96
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_rs;
  logic              in_use_rs;
  logic [REG_W-1:0]  in_rt;
  logic              in_use_rt;
  logic [REG_W-1:0]  in_rd;
  logic              in_wr;
  logic              in_is_load;
  logic              in_is_mc;
  logic              in_is_link;
  logic [CTRL_W-1:0] in_ctrl;
  logic [PAY_W-1:0]  in_payload;
  logic              flush;
  logic              ex_hold;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [REG_W-1:0]  ex_dest;
  logic [PAY_W-1:0]  ex_payload;
  logic              mc_busy;

  modport master (
    output in_valid, in_rs, in_use_rs, in_rt, in_use_rt, in_rd, in_wr,
           in_is_load, in_is_mc, in_is_link, in_ctrl, in_payload, flush, ex_hold,
    input  in_ready, ex_valid, ex_ctrl, ex_dest, ex_payload, mc_busy
  );

  modport slave (
    input  in_valid, in_rs, in_use_rs, in_rt, in_use_rt, in_rd, in_wr,
           in_is_load, in_is_mc, in_is_link, in_ctrl, in_payload, flush, ex_hold,
    output in_ready, ex_valid, ex_ctrl, ex_dest, ex_payload, mc_busy
  );
endinterface

// File: rtl/id_issue_interlock.sv
// ID/EX pipeline register with a per-register countdown scoreboard: RAW and
// multi-cycle structural hazards insert bubbles and backpressure fetch.
module id_issue_interlock #(
  parameter int NREGS    = 32,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 9,
  parameter int PAY_W    = 96,
  parameter int CNT_W    = 4,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int MC_LAT   = 10,
  parameter int LINK_REG = 31
) (
  input  logic clk,
  input  logic rst_n,
  id_issue_if.slave bus
);

  localparam logic [CNT_W-1:0] L_ALU  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] L_LOAD = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] L_MC   = CNT_W'(MC_LAT);
  localparam logic [REG_W-1:0] LINK   = REG_W'(LINK_REG);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  logic [CNT_W-1:0]  r_cnt [NREGS];
  logic [CNT_W-1:0]  r_mc_cnt;
  logic              r_vld_p1;
  logic [CTRL_W-1:0] r_ctrl_p1;
  logic [REG_W-1:0]  r_dest_p1;
  logic [PAY_W-1:0]  r_pay_p1;

  logic [REG_W-1:0]  w_dest;
  logic [CNT_W-1:0]  w_lat;
  logic [CNT_W-1:0]  w_rs_cnt;
  logic [CNT_W-1:0]  w_rt_cnt;
  logic              w_raw;
  logic              w_struct;
  logic              w_issue;
  logic              w_set;
  logic              w_mc_busy;

  // ---- p0: decode-side hazard evaluation against pre-issue counts ----
  always_comb begin
    w_dest = bus.in_is_link ? LINK : bus.in_rd;
    if (bus.in_is_mc)        w_lat = L_MC;
    else if (bus.in_is_load) w_lat = L_LOAD;
    else                     w_lat = L_ALU;
  end

  // Register 0 is skipped, so its lookup always reads as ready.
  always_comb begin
    w_rs_cnt = '0;
    w_rt_cnt = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (bus.in_rs == REG_W'(i)) w_rs_cnt = r_cnt[i];
      if (bus.in_rt == REG_W'(i)) w_rt_cnt = r_cnt[i];
    end
  end

  assign w_mc_busy = (r_mc_cnt != '0);
  assign w_raw     = bus.in_valid & ((bus.in_use_rs & (w_rs_cnt != '0)) |
                                     (bus.in_use_rt & (w_rt_cnt != '0)));
  assign w_struct  = bus.in_valid & bus.in_is_mc & w_mc_busy;
  assign w_issue   = ~bus.ex_hold & ~bus.flush & bus.in_valid & ~w_raw & ~w_struct;
  assign w_set     = w_issue & bus.in_wr & (w_dest != '0);

  assign bus.in_ready = ~bus.ex_hold & ~w_raw & ~w_struct;

  // ---- p1: ID/EX register and scoreboard update ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_ctrl_p1 <= '0;
      r_dest_p1 <= '0;
      r_pay_p1  <= '0;
      r_mc_cnt  <= '0;
      for (int i = 0; i < NREGS; i++) r_cnt[i] <= '0;
    end else if (!bus.ex_hold) begin
      r_vld_p1  <= w_issue;
      r_ctrl_p1 <= w_issue ? bus.in_ctrl : '0;
      r_dest_p1 <= w_issue ? w_dest : '0;
      if (w_issue) r_pay_p1 <= bus.in_payload;
      r_mc_cnt  <= (w_issue && bus.in_is_mc) ? L_MC : sat_dec(r_mc_cnt);
      for (int i = 0; i < NREGS; i++) begin
        if (i != 0 && w_set && w_dest == REG_W'(i)) r_cnt[i] <= w_lat;
        else                                         r_cnt[i] <= sat_dec(r_cnt[i]);
      end
    end
  end

  assign bus.ex_valid   = r_vld_p1;
  assign bus.ex_ctrl    = r_ctrl_p1;
  assign bus.ex_dest    = r_dest_p1;
  assign bus.ex_payload = r_pay_p1;
  assign bus.mc_busy    = w_mc_busy;

endmodule

// File: tb/tb_id_issue_interlock.sv
// Bench for id_issue_interlock: directed hazard scenarios plus randomized traffic,
// checked against a timestamp-based model of register and multi-cycle readiness.
module tb_id_issue_interlock;

  logic clk;
  logic rst_n;

  id_issue_if #(.REG_W(5), .CTRL_W(9), .PAY_W(96)) bus ();

  id_issue_interlock dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  int n_vec;
  int n_err;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: time is counted in non-held edges; a register is readable at the
  // edge whose index reaches its ready time.
  int unsigned m;
  int unsigned ready_at [32];
  int unsigned mc_free;
  logic        e_vld;
  logic [8:0]  e_ctrl;
  logic [4:0]  e_dest;
  logic [95:0] e_pay;
  bit          consumed;

  function automatic int unsigned lat_of();
    if (bus.in_is_mc)   return 10;
    if (bus.in_is_load) return 1;
    return 0;
  endfunction

  function automatic bit src_busy(input bit use_r, input logic [4:0] r);
    return use_r && (r != 5'd0) && (m < ready_at[r]);
  endfunction

  function automatic bit hazard();
    return bus.in_valid && (src_busy(bus.in_use_rs, bus.in_rs) ||
                            src_busy(bus.in_use_rt, bus.in_rt) ||
                            (bus.in_is_mc && m < mc_free));
  endfunction

  task automatic model_reset();
    m = 0;
    mc_free = 0;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    e_vld = 0; e_ctrl = '0; e_dest = '0; e_pay = '0;
  endtask

  task automatic model_edge();
    bit h;
    logic [4:0] d;
    if (bus.ex_hold) begin
      consumed = 0;
      return;
    end
    h = hazard();
    if (bus.in_valid && !bus.flush && !h) begin
      d = bus.in_is_link ? 5'd31 : bus.in_rd;
      e_vld = 1; e_ctrl = bus.in_ctrl; e_dest = d; e_pay = bus.in_payload;
      if (bus.in_wr && d != 5'd0) ready_at[d] = m + lat_of() + 1;
      if (bus.in_is_mc) mc_free = m + 10 + 1;
    end else begin
      e_vld = 0; e_ctrl = '0; e_dest = '0;
    end
    consumed = !bus.in_valid || bus.flush || !h;
    m++;
  endtask

  task automatic step();
    #1;
    chk_eq("in_ready", bus.in_ready, !bus.ex_hold && !hazard());
    chk_eq("mc_busy", bus.mc_busy, m < mc_free);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_eq("ex_valid", bus.ex_valid, e_vld);
    chk_eq("ex_ctrl", bus.ex_ctrl, e_ctrl);
    chk_eq("ex_dest", bus.ex_dest, e_dest);
    chk_eq("ex_payload", bus.ex_payload, e_pay);
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
    bus.in_use_rs = 0; bus.in_use_rt = 0; bus.in_wr = 0;
    bus.in_is_load = 0; bus.in_is_mc = 0; bus.in_is_link = 0;
    bus.in_ctrl = '0; bus.in_payload = '0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit wr,
                       input bit ld, input bit mc, input bit lk);
    bus.in_valid = 1; bus.in_rd = rd; bus.in_rs = rs; bus.in_rt = rt;
    bus.in_use_rs = urs; bus.in_use_rt = urt; bus.in_wr = wr;
    bus.in_is_load = ld; bus.in_is_mc = mc; bus.in_is_link = lk;
    bus.in_ctrl = 9'($urandom);
    bus.in_payload = {$urandom, $urandom, $urandom};
  endtask

  function automatic logic [4:0] rnd_reg();
    if ($urandom_range(0, 4) == 0) return 5'd0;
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(1, 6));
  endfunction

  int stalls;

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 0;
    bus.flush = 0; bus.ex_hold = 0;
    idle();
    model_reset();
    consumed = 1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    #1;
    chk_eq("rst_ex_valid", bus.ex_valid, 1'b0);
    chk_eq("rst_ex_payload", bus.ex_payload, 96'd0);
    chk_eq("rst_mc_busy", bus.mc_busy, 1'b0);
    @(negedge clk);

    // T1: async reset while add waits on a load
    instr(5'd4, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    step();
    chk_eq("t1_lw_dest", bus.ex_dest, 5'd4);
    instr(5'd5, 5'd4, 5'd2, 1, 1, 1, 0, 0, 0);
    #1;
    chk_eq("t1_stall_ready", bus.in_ready, 1'b0);
    #2 rst_n = 0;
    #1;
    chk_eq("t1_rst_valid", bus.ex_valid, 1'b0);
    chk_eq("t1_rst_ctrl", bus.ex_ctrl, 9'd0);
    chk_eq("t1_rst_dest", bus.ex_dest, 5'd0);
    chk_eq("t1_rst_payload", bus.ex_payload, 96'd0);
    chk_eq("t1_rst_mc_busy", bus.mc_busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    #1;
    chk_eq("t1_ready_after_rst", bus.in_ready, 1'b1);
    step();
    chk_eq("t1_add_issued", bus.ex_valid, 1'b1);

    // T2: load-use costs exactly one bubble
    instr(5'd4, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    step();
    instr(5'd5, 5'd4, 5'd2, 1, 1, 1, 0, 0, 0);
    step();
    chk_eq("t2_bubble", bus.ex_valid, 1'b0);
    step();
    chk_eq("t2_add_issue", bus.ex_valid, 1'b1);
    chk_eq("t2_add_dest", bus.ex_dest, 5'd5);

    // T3: ALU back-to-back
    instr(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
    step();
    chk_eq("t3_add", bus.ex_valid, 1'b1);
    instr(5'd2, 5'd1, 5'd1, 1, 1, 1, 0, 0, 0);
    step();
    chk_eq("t3_sub", bus.ex_valid, 1'b1);

    // T4: second multi-cycle op waits for the unit, dependent add follows in order
    instr(5'd6, 5'd1, 5'd2, 1, 1, 1, 0, 1, 0);
    step();
    chk_eq("t4_mult1", bus.ex_valid, 1'b1);
    instr(5'd7, 5'd1, 5'd2, 1, 1, 1, 0, 1, 0);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.ex_valid) break;
      stalls++;
    end
    chk_eq("t4_stall_cycles", stalls, 10);
    chk_eq("t4_mult2_dest", bus.ex_dest, 5'd7);
    instr(5'd8, 5'd6, 5'd0, 1, 0, 1, 0, 0, 0);
    step();
    chk_eq("t4_add_no_bubble", bus.ex_valid, 1'b1);
    chk_eq("t4_add_dest", bus.ex_dest, 5'd8);

    // T5: link destination and register 0
    instr(5'd9, 5'd0, 5'd0, 0, 0, 1, 0, 0, 1);
    step();
    chk_eq("t5_link_dest", bus.ex_dest, 5'd31);
    instr(5'd0, 5'd3, 5'd0, 1, 0, 1, 1, 0, 0);
    step();
    instr(5'd3, 5'd0, 5'd31, 1, 1, 1, 0, 0, 0);
    step();
    chk_eq("t5_r0_reader", bus.ex_valid, 1'b1);

    // T6: flushed load sets nothing; hold freezes counts and EX
    instr(5'd4, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    bus.flush = 1;
    step();
    chk_eq("t6_flush_bubble", bus.ex_valid, 1'b0);
    bus.flush = 0;
    instr(5'd5, 5'd4, 5'd4, 1, 1, 1, 0, 0, 0);
    step();
    chk_eq("t6_no_countdown", bus.ex_valid, 1'b1);
    instr(5'd4, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
    step();
    instr(5'd5, 5'd4, 5'd2, 1, 1, 1, 0, 0, 0);
    bus.ex_hold = 1;
    repeat (3) begin
      step();
      chk_eq("t6_hold_dest", bus.ex_dest, 5'd4);
      chk_eq("t6_hold_valid", bus.ex_valid, 1'b1);
    end
    bus.ex_hold = 0;
    step();
    chk_eq("t6_bubble_after_hold", bus.ex_valid, 1'b0);
    step();
    chk_eq("t6_add_issue", bus.ex_valid, 1'b1);

    // Randomized traffic; a stalled instruction is re-presented unchanged
    consumed = 1;
    for (int k = 0; k < 600; k++) begin
      bus.ex_hold = ($urandom_range(0, 9) == 0);
      bus.flush   = ($urandom_range(0, 11) == 0);
      if (consumed) begin
        if ($urandom_range(0, 4) == 0) idle();
        else instr(rnd_reg(), rnd_reg(), rnd_reg(),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                   $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0);
      end
      step();
    end

    bus.ex_hold = 0; bus.flush = 0;
    idle();
    repeat (12) step();
    chk_eq("drain_mc_busy", bus.mc_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
